// File: rtl/calc_pkg.sv
// calc_pkg: shared BCD digit type and single-digit increment/decrement helpers with carry/borrow
package calc_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  typedef struct packed {
    logic c;
    bcd_digit_t d;
  } bcd_res_t;
  function automatic bcd_res_t bcd_inc(bcd_digit_t d, logic ci);
    bcd_inc = '{c: ci && d == BCD_MAX, d: !ci ? d : d == BCD_MAX ? 4'd0 : d + 4'd1};
  endfunction
  function automatic bcd_res_t bcd_dec(bcd_digit_t d, logic bi);
    bcd_dec = '{c: bi && d == 4'd0, d: !bi ? d : d == 4'd0 ? BCD_MAX : d - 4'd1};
  endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: sync + debounce + press pulse + hold-to-repeat; ports clk, rst, btn in; press, rpt out
module btn_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter int RPT_DELAY = 0,
  parameter int RPT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic rpt
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = RPT_DELAY > 0 ? $clog2(RPT_DELAY + 1) : 1;
  logic s1, s2, deb, deb_q;
  logic [DW-1:0] deb_cnt;
  logic [RW-1:0] rpt_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      deb <= 1'b0;
      deb_q <= 1'b0;
      deb_cnt <= '0;
      rpt_cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      deb_q <= deb;
      deb_cnt <= s2 != deb ? deb_cnt + 1'b1 : '0;
      if (s2 != deb && deb_cnt == DW'(DEB_CYCLES - 1)) deb <= s2;
      rpt_cnt <= !deb ? '0 : rpt ? RW'(RPT_DELAY - RPT_PERIOD + 1) : rpt_cnt + 1'b1;
    end
  end
  assign press = deb & ~deb_q;
  assign rpt = RPT_DELAY != 0 && deb && rpt_cnt == RW'(RPT_DELAY);
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: NDIG-digit BCD up/down/clear counter from raw buttons; value out (digit 0 in [3:0]), ovf/unf pulses
module bcd_updown_counter
  import calc_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DEB_CYCLES = 16,
  parameter int RPT_DELAY = 0,
  parameter int RPT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_dn,
  input  logic btn_clr,
  input  logic sat_mode,
  output logic [4*NDIG-1:0] value,
  output logic ovf,
  output logic unf
);
  logic up_p, up_r, dn_p, dn_r, clr_p, clr_r;
  logic clr, step_up, step_dn, up_only, dn_only;
  logic [NDIG:0] c, b;
  logic [4*NDIG-1:0] inc_v, dec_v;
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_up (
    .clk(clk), .rst(rst), .btn(btn_up), .press(up_p), .rpt(up_r)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_dn (
    .clk(clk), .rst(rst), .btn(btn_dn), .press(dn_p), .rpt(dn_r)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .RPT_DELAY(0), .RPT_PERIOD(RPT_PERIOD)) u_clr (
    .clk(clk), .rst(rst), .btn(btn_clr), .press(clr_p), .rpt(clr_r)
  );
  assign clr = clr_p | clr_r;
  assign step_up = up_p | up_r;
  assign step_dn = dn_p | dn_r;
  assign up_only = step_up & ~step_dn & ~clr;
  assign dn_only = step_dn & ~step_up & ~clr;
  assign c[0] = 1'b1;
  assign b[0] = 1'b1;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_res_t ri, rd;
    assign ri = bcd_inc(value[4*i+:4], c[i]);
    assign rd = bcd_dec(value[4*i+:4], b[i]);
    assign inc_v[4*i+:4] = ri.d;
    assign dec_v[4*i+:4] = rd.d;
    assign c[i+1] = ri.c;
    assign b[i+1] = rd.c;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      value <= clr ? '0
             : up_only ? (c[NDIG] && sat_mode ? value : inc_v)
             : dn_only ? (b[NDIG] && sat_mode ? value : dec_v)
             : value;
      ovf <= up_only & c[NDIG];
      unf <= dn_only & b[NDIG];
    end
  end
endmodule
